// File: rtl/serial_rx_deserializer.sv
// 8N1 serial receiver: synchronizes SIn, deserializes LSB-first frames and
// holds each received byte in a one-entry valid/ready output buffer.
module serial_rx_deserializer #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SIn,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  output logic       FramingError,
  output logic       Overrun
);

  localparam int unsigned BIT_TIME  = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_TIME = BIT_TIME / 2;
  localparam int unsigned CNT_W     = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TIME - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TIME - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} RxState;

  RxState           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [2:0]       bitIdx, bitIdxNext;
  logic [7:0]       shiftReg, shiftNext;
  logic [7:0]       dataNext;
  logic             validNext, ferrNext, ovrNext;
  logic             sync1, sync2;
  logic             primed, armed;

  // Next-state, datapath and output-buffer decisions.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    dataNext   = DataOut;
    validNext  = DataOutValid && !DataOutReady;
    ferrNext   = 1'b0;
    ovrNext    = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !sync2) begin
          stateNext = START;
          cntNext   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cntNext    = '0;
          bitIdxNext = 3'd0;
          stateNext  = sync2 ? IDLE : DATA;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cntNext           = '0;
          shiftNext[bitIdx] = sync2;
          bitIdxNext        = bitIdx + 3'd1;
          if (bitIdx == 3'd7) stateNext = STOP;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cntNext   = '0;
          stateNext = IDLE;
          if (!sync2) begin
            ferrNext = 1'b1;
          end else if (DataOutValid && !DataOutReady) begin
            ovrNext = 1'b1;
          end else begin
            dataNext  = shiftReg;
            validNext = 1'b1;
          end
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // armed requires a genuinely sampled high line after reset, so the tail
  // of a frame cut by reset cannot be mistaken for a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      primed       <= 1'b0;
      armed        <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      bitIdx       <= 3'd0;
      shiftReg     <= 8'h00;
      DataOut      <= 8'h00;
      DataOutValid <= 1'b0;
      FramingError <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      sync1        <= SIn;
      sync2        <= sync1;
      primed       <= 1'b1;
      armed        <= armed || (primed && sync1);
      state        <= stateNext;
      cnt          <= cntNext;
      bitIdx       <= bitIdxNext;
      shiftReg     <= shiftNext;
      DataOut      <= dataNext;
      DataOutValid <= validNext;
      FramingError <= ferrNext;
      Overrun      <= ovrNext;
    end
  end

endmodule

// File: tb/tb_serial_rx_deserializer.sv
// Self-checking bench for serial_rx_deserializer: directed scenarios plus
// randomized frames against a byte-level reference model.
module tb_serial_rx_deserializer;

  localparam int unsigned CF   = 1_700_000;
  localparam int unsigned BR   = 100_000;
  localparam int unsigned BIT  = CF / BR;
  localparam int unsigned HALF = BIT / 2;
  // Valid rises this many cycles after the cycle the bench drives the start bit.
  localparam int unsigned LAT  = 3 + HALF + 9 * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SIn = 1'b1;
  logic       DataOutReady = 1'b0;
  logic [7:0] DataOut;
  logic       DataOutValid, FramingError, Overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frameStart = 0;

  int fePulses, feCycles, ovPulses, ovCycles, stabErr, riseCyc;
  logic prevFe = 1'b0, prevOv = 1'b0, prevValid = 1'b0, prevHold = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic [7:0] delivered[$];

  serial_rx_deserializer #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk(clk), .rst(rst), .SIn(SIn), .DataOut(DataOut),
    .DataOutValid(DataOutValid), .DataOutReady(DataOutReady),
    .FramingError(FramingError), .Overrun(Overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pulse widths, handshakes, hold stability, valid rise time.
  always @(negedge clk) begin
    if (FramingError) feCycles++;
    if (FramingError && !prevFe) fePulses++;
    if (Overrun) ovCycles++;
    if (Overrun && !prevOv) ovPulses++;
    if (DataOutValid && !prevValid) riseCyc = cyc;
    if (prevHold && !rst && DataOut !== prevData) stabErr++;
    if (DataOutValid && DataOutReady) delivered.push_back(DataOut);
    prevHold  = DataOutValid && !DataOutReady && !rst;
    prevData  = DataOut;
    prevFe    = FramingError;
    prevOv    = Overrun;
    prevValid = DataOutValid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearMon();
    fePulses = 0; feCycles = 0; ovPulses = 0; ovCycles = 0;
    stabErr = 0; riseCyc = -1;
    delivered.delete();
  endtask

  // Drives start, 8 data bits LSB first, stop; optional reset during data bit rstBit.
  task automatic sendFrame(input logic [7:0] b, input logic stopVal, input int rstBit);
    logic [9:0] f;
    f = {stopVal, b, 1'b0};
    frameStart = cyc;
    for (int i = 0; i < 10; i++) begin
      SIn = f[i];
      if (rstBit >= 0 && i == rstBit + 1) begin
        step(HALF);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(BIT - HALF - 3);
      end else begin
        step(BIT);
      end
    end
    SIn = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(4);
    checks++; if (DataOut !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", DataOut); end
    checks++; if (DataOutValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", DataOutValid); end
    checks++; if (FramingError !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", FramingError); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", Overrun); end
    rst = 1'b0;
    step(5);
  endtask

  task automatic test_basic();
    clearMon();
    DataOutReady = 1'b0;
    sendFrame(8'hA5, 1'b1, -1);
    step(3 * BIT);
    checks++; if (riseCyc != frameStart + int'(LAT)) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", riseCyc - frameStart, LAT); end
    checks++; if (DataOutValid !== 1'b1 || DataOut !== 8'hA5) begin errors++; $display("FAIL basic_hold: got v=%b d=%0h expected v=1 d=a5", DataOutValid, DataOut); end
    checks++; if (stabErr != 0 || fePulses != 0) begin errors++; $display("FAIL basic_stable: got stab=%0d fe=%0d expected 0 0", stabErr, fePulses); end
    DataOutReady = 1'b1;
    step(1);
    DataOutReady = 1'b0;
    checks++; if (DataOutValid !== 1'b0) begin errors++; $display("FAIL basic_consume: got %b expected 0", DataOutValid); end
    checks++; if (delivered.size() != 1 || delivered[0] !== 8'hA5) begin errors++; $display("FAIL basic_delivered: got n=%0d expected 1 byte a5", delivered.size()); end
    step(5);
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    clearMon();
    DataOutReady = 1'b1;
    SIn = 1'b0;
    step(5);
    SIn = 1'b1;
    step(3 * BIT);
    checks++; if (riseCyc != -1 || fePulses != 0) begin errors++; $display("FAIL glitch_quiet: got rise=%0d fe=%0d expected -1 0", riseCyc, fePulses); end
    b = 8'($urandom);
    sendFrame(b, 1'b1, -1);
    step(BIT);
    checks++; if (delivered.size() != 1 || delivered[0] !== b) begin errors++; $display("FAIL glitch_recover: got n=%0d expected 1 byte %0h", delivered.size(), b); end
  endtask

  task automatic test_framing();
    clearMon();
    DataOutReady = 1'b0;
    sendFrame(8'h3C, 1'b0, -1);
    step(BIT);
    checks++; if (fePulses != 1 || feCycles != 1) begin errors++; $display("FAIL framing_pulse: got pulses=%0d cycles=%0d expected 1 1", fePulses, feCycles); end
    checks++; if (DataOutValid !== 1'b0 || ovPulses != 0) begin errors++; $display("FAIL framing_novalid: got v=%b ov=%0d expected 0 0", DataOutValid, ovPulses); end
  endtask

  task automatic test_overrun();
    clearMon();
    DataOutReady = 1'b0;
    sendFrame(8'h11, 1'b1, -1);
    step(5);
    sendFrame(8'h22, 1'b1, -1);
    step(BIT);
    checks++; if (ovPulses != 1 || ovCycles != 1) begin errors++; $display("FAIL overrun_pulse: got pulses=%0d cycles=%0d expected 1 1", ovPulses, ovCycles); end
    checks++; if (DataOut !== 8'h11 || DataOutValid !== 1'b1 || stabErr != 0) begin errors++; $display("FAIL overrun_keep: got d=%0h v=%b stab=%0d expected 11 1 0", DataOut, DataOutValid, stabErr); end
    DataOutReady = 1'b1;
    step(1);
    DataOutReady = 1'b0;
    checks++; if (DataOutValid !== 1'b0 || delivered.size() != 1) begin errors++; $display("FAIL overrun_consume: got v=%b n=%0d expected 0 1", DataOutValid, delivered.size()); end
  endtask

  task automatic test_back_to_back();
    logic       vSeen;
    logic [7:0] dSeen;
    clearMon();
    DataOutReady = 1'b0;
    sendFrame(8'h44, 1'b1, -1);
    step(5);
    fork
      sendFrame(8'h55, 1'b1, -1);
      begin
        step(LAT - 1);
        DataOutReady = 1'b1;
        step(1);
        DataOutReady = 1'b0;
        vSeen = DataOutValid;
        dSeen = DataOut;
      end
    join
    step(BIT);
    checks++; if (vSeen !== 1'b1 || dSeen !== 8'h55) begin errors++; $display("FAIL b2b_load: got v=%b d=%0h expected 1 55", vSeen, dSeen); end
    checks++; if (ovPulses != 0 || delivered.size() != 1 || delivered[0] !== 8'h44) begin errors++; $display("FAIL b2b_transfer: got ov=%0d n=%0d expected 0 1 (44)", ovPulses, delivered.size()); end
    DataOutReady = 1'b1;
    step(1);
    DataOutReady = 1'b0;
    checks++; if (delivered.size() != 2 || delivered[1] !== 8'h55) begin errors++; $display("FAIL b2b_second: got n=%0d expected 2 (55)", delivered.size()); end
  endtask

  task automatic test_reset_midframe();
    clearMon();
    DataOutReady = 1'b1;
    sendFrame(8'h0F, 1'b1, 4);
    step(BIT);
    sendFrame(8'h81, 1'b1, -1);
    step(BIT);
    checks++; if (delivered.size() != 1 || delivered[0] !== 8'h81) begin errors++; $display("FAIL midreset_only: got n=%0d expected 1 byte 81", delivered.size()); end
    checks++; if (fePulses != 0 || ovPulses != 0) begin errors++; $display("FAIL midreset_err: got fe=%0d ov=%0d expected 0 0", fePulses, ovPulses); end
  endtask

  task automatic test_reset_start();
    logic [7:0] b;
    DataOutReady = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    clearMon();
    step(1);
    b = 8'($urandom);
    sendFrame(b, 1'b1, -1);
    step(BIT);
    checks++; if (delivered.size() != 1 || delivered[0] !== b) begin errors++; $display("FAIL rststart_frame: got n=%0d expected 1 byte %0h", delivered.size(), b); end
  endtask

  task automatic test_random();
    logic [7:0] exp[$];
    logic [7:0] b;
    logic       ok;
    int         expFe;
    clearMon();
    expFe = 0;
    DataOutReady = 1'b1;
    for (int n = 0; n < 20; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      sendFrame(b, ok, -1);
      if (ok) begin
        exp.push_back(b);
        checks++; if (riseCyc != frameStart + int'(LAT)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, riseCyc - frameStart, LAT); end
      end else begin
        expFe++;
      end
      step($urandom_range(0, BIT));
    end
    step(BIT);
    checks++; if (delivered.size() != exp.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", delivered.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < delivered.size(); i++) begin
      checks++; if (delivered[i] !== exp[i]) begin errors++; $display("FAIL rand_byte[%0d]: got %0h expected %0h", i, delivered[i], exp[i]); end
    end
    checks++; if (fePulses != expFe || feCycles != expFe || ovPulses != 0) begin errors++; $display("FAIL rand_errors: got fe=%0d/%0d ov=%0d expected %0d 0", fePulses, feCycles, ovPulses, expFe); end
  endtask

  initial begin
    clearMon();
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_reset_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
